// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C Triple-DES slave transmit path.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ACK_WAIT,
    ACK_HOLD
  } tx_state_t;

  localparam int unsigned I2C_BYTE_W    = 8;
  localparam logic [7:0]  I2C_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/tx_shift_reg.sv
// Parallel-load / shift-left register feeding the SDA bit stream, MSB first.
module tx_shift_reg #(
  parameter int unsigned         DATA_W  = 8,
  parameter logic [DATA_W-1:0]   RST_VAL = '1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  output logic              msb
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q <= RST_VAL;
    end else if (load) begin
      data_q <= load_data;
    end else if (shift) begin
      data_q <= {data_q[DATA_W-2:0], 1'b0};
    end
  end

  assign msb = data_q[DATA_W-1];

endmodule

// File: rtl/i2c_tx_byte_sender.sv
// Serialises tx_fifo bytes onto SDA for master-read transfers and handles ACK/NACK.
// Optional byte counter output enabled by defining TX_BYTE_CNT_EN.
module i2c_tx_byte_sender
  import i2c_pkg::*;
#(
  parameter int unsigned       DATA_W    = I2C_BYTE_W,
  parameter logic [DATA_W-1:0] FILL_BYTE = I2C_FILL_BYTE
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_tx,
  input  logic              stop_detect,
  input  logic              scl_rising,
  input  logic              scl_falling,
  input  logic              sda_in,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] read_data,
  output logic              read_enable,
  output logic              sda_out,
  output logic              tx_active,
  output logic              ack_pulse,
  output logic              nack_pulse,
  output logic              underrun
`ifdef TX_BYTE_CNT_EN
  ,
  output logic [15:0]       tx_byte_count
`endif
);

  localparam int unsigned       CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              ack_q, ack_d, nack_q, nack_d, und_q, und_d;
  logic              rise_v, fall_v, load, shift, shreg_msb;
  logic [DATA_W-1:0] load_data;

  // Coincident edges are illegal and both are discarded.
  assign rise_v = scl_rising & ~scl_falling;
  assign fall_v = scl_falling & ~scl_rising;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ack_d     = 1'b0;
    nack_d    = 1'b0;
    und_d     = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    if (stop_detect) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_tx) begin
            load    = 1'b1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (fall_v) begin
            if (bit_cnt_q == LAST_BIT) begin
              state_d = ACK_WAIT;
            end else begin
              shift     = 1'b1;
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        ACK_WAIT: begin
          if (rise_v) begin
            if (!sda_in) begin
              ack_d   = 1'b1;
              state_d = ACK_HOLD;
            end else begin
              nack_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        ACK_HOLD: begin
          if (fall_v) begin
            load    = 1'b1;
            state_d = SHIFT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (load) begin
      bit_cnt_d = '0;
      und_d     = fifo_empty;
    end
  end

  assign load_data   = fifo_empty ? FILL_BYTE : read_data;
  assign read_enable = load & ~fifo_empty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      und_q     <= und_d;
    end
  end

  tx_shift_reg #(
    .DATA_W  (DATA_W),
    .RST_VAL (FILL_BYTE)
  ) u_shift_reg (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (load),
    .shift     (shift),
    .load_data (load_data),
    .msb       (shreg_msb)
  );

  // SDA is decoded from registered state only, so an async reset releases it at once.
  assign sda_out    = (state_q == SHIFT) ? shreg_msb : 1'b1;
  assign tx_active  = (state_q != IDLE);
  assign ack_pulse  = ack_q;
  assign nack_pulse = nack_q;
  assign underrun   = und_q;

`ifdef TX_BYTE_CNT_EN
  logic [15:0] byte_cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_cnt_q <= '0;
    end else if (load && (state_q == IDLE)) begin
      byte_cnt_q <= '0;
    end else if ((ack_d || nack_d) && (byte_cnt_q != '1)) begin
      byte_cnt_q <= byte_cnt_q + 16'd1;
    end
  end

  assign tx_byte_count = byte_cnt_q;
`endif

endmodule

// File: tb/tb_i2c_tx_byte_sender.sv
// Self-checking bench for i2c_tx_byte_sender with a queue-style FIFO and bus master model.
module tb_i2c_tx_byte_sender;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start_tx = 1'b0, stop_detect = 1'b0;
  logic       scl_rising = 1'b0, scl_falling = 1'b0, sda_in = 1'b1;
  logic       fifo_empty;
  logic [7:0] read_data;
  logic       read_enable, sda_out, tx_active, ack_pulse, nack_pulse, underrun;
`ifdef TX_BYTE_CNT_EN
  logic [15:0] tx_byte_count;
`endif

  int unsigned n_chk = 0, n_pass = 0;

  // FIFO model: mem written only by stimulus, rd_ptr advanced only by pops.
  logic [7:0]  fifo_mem [16];
  int unsigned wr_ptr = 0, rd_ptr = 0;
  int unsigned ack_cnt = 0, nack_cnt = 0, und_cnt = 0, bad_pop = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign read_data  = fifo_mem[rd_ptr % 16];

  always #5 clk = ~clk;

  i2c_tx_byte_sender #(.DATA_W(8), .FILL_BYTE(8'hFF)) dut (
    .clk(clk), .n_rst(n_rst), .start_tx(start_tx), .stop_detect(stop_detect),
    .scl_rising(scl_rising), .scl_falling(scl_falling), .sda_in(sda_in),
    .fifo_empty(fifo_empty), .read_data(read_data), .read_enable(read_enable),
    .sda_out(sda_out), .tx_active(tx_active), .ack_pulse(ack_pulse),
    .nack_pulse(nack_pulse), .underrun(underrun)
`ifdef TX_BYTE_CNT_EN
    , .tx_byte_count(tx_byte_count)
`endif
  );

  always @(posedge clk) begin
    if (read_enable) begin
      if (fifo_empty) bad_pop <= bad_pop + 1;
      else            rd_ptr  <= rd_ptr + 1;
    end
    if (ack_pulse)  ack_cnt  <= ack_cnt + 1;
    if (nack_pulse) nack_cnt <= nack_cnt + 1;
    if (underrun)   und_cnt  <= und_cnt + 1;
  end

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr % 16] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic start();
    start_tx = 1'b1;
    @(negedge clk);
    start_tx = 1'b0;
  endtask

  task automatic bit_clock(output logic b);
    gap();
    b = sda_out;
    scl_rising = 1'b1;
    @(negedge clk);
    scl_rising = 1'b0;
    gap();
    scl_falling = 1'b1;
    @(negedge clk);
    scl_falling = 1'b0;
  endtask

  task automatic master_byte(input bit ack, output logic [7:0] got, output logic ack_sda);
    logic b;
    for (int i = 0; i < 8; i++) begin
      bit_clock(b);
      got[7-i] = b;
    end
    gap();
    sda_in  = ack ? 1'b0 : 1'b1;
    ack_sda = sda_out;
    scl_rising = 1'b1;
    @(negedge clk);
    scl_rising = 1'b0;
    gap();
    scl_falling = 1'b1;
    @(negedge clk);
    scl_falling = 1'b0;
    sda_in = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({sda_out, tx_active, read_enable, ack_pulse, nack_pulse, underrun} !== 6'b100000)
      $display("FAIL reset_outputs: got %b expected 100000",
               {sda_out, tx_active, read_enable, ack_pulse, nack_pulse, underrun});
    else n_pass++;
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] got; logic asda;
    int unsigned p0 = rd_ptr, a0 = ack_cnt, n0 = nack_cnt;
    push(8'hA5);
    start();
    n_chk++;
    if (sda_out !== 1'b1) $display("FAIL basic_msb_latency: got %b expected 1", sda_out);
    else n_pass++;
    master_byte(1'b0, got, asda);
    repeat (2) @(negedge clk);
    n_chk++;
    if (got !== 8'hA5) $display("FAIL basic_byte: got %h expected a5", got); else n_pass++;
    n_chk++;
    if (asda !== 1'b1) $display("FAIL basic_ack_release: got %b expected 1", asda); else n_pass++;
    n_chk++;
    if (rd_ptr - p0 != 1) $display("FAIL basic_pops: got %0d expected 1", rd_ptr - p0); else n_pass++;
    n_chk++;
    if (nack_cnt - n0 != 1 || ack_cnt != a0)
      $display("FAIL basic_nack: got nack %0d ack %0d expected 1 0", nack_cnt - n0, ack_cnt - a0);
    else n_pass++;
    n_chk++;
    if (tx_active !== 1'b0) $display("FAIL basic_idle: got %b expected 0", tx_active); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] g1, g2; logic asda;
    int unsigned p0 = rd_ptr, a0 = ack_cnt, n0 = nack_cnt;
    push(8'h3C); push(8'hC3);
    start();
    master_byte(1'b1, g1, asda);
    master_byte(1'b0, g2, asda);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({g1, g2} !== 16'h3CC3) $display("FAIL b2b_bytes: got %h expected 3cc3", {g1, g2}); else n_pass++;
    n_chk++;
    if (rd_ptr - p0 != 2) $display("FAIL b2b_pops: got %0d expected 2", rd_ptr - p0); else n_pass++;
    n_chk++;
    if (ack_cnt - a0 != 1 || nack_cnt - n0 != 1)
      $display("FAIL b2b_acknack: got %0d/%0d expected 1/1", ack_cnt - a0, nack_cnt - n0);
    else n_pass++;
    n_chk++;
    if (fifo_empty !== 1'b1) $display("FAIL b2b_empty: got %b expected 1", fifo_empty); else n_pass++;
  endtask

  task automatic test_underrun();
    logic [7:0] g1, g2; logic asda;
    int unsigned p0 = rd_ptr, u0 = und_cnt, b0 = bad_pop;
    push(8'h81);
    start();
    master_byte(1'b1, g1, asda);
    master_byte(1'b0, g2, asda);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({g1, g2} !== 16'h81FF) $display("FAIL underrun_bytes: got %h expected 81ff", {g1, g2}); else n_pass++;
    n_chk++;
    if (und_cnt - u0 != 1) $display("FAIL underrun_pulse: got %0d expected 1", und_cnt - u0); else n_pass++;
    n_chk++;
    if (rd_ptr - p0 != 1 || bad_pop != b0)
      $display("FAIL underrun_pops: got %0d bad %0d expected 1 0", rd_ptr - p0, bad_pop - b0);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic b; logic [7:0] got; logic asda;
    int unsigned a0 = ack_cnt, n0 = nack_cnt;
    push(8'h0F);
    start();
    for (int i = 0; i < 3; i++) bit_clock(b);
    gap();
    stop_detect = 1'b1;
    @(negedge clk);
    stop_detect = 1'b0;
    n_chk++;
    if ({tx_active, sda_out} !== 2'b01)
      $display("FAIL abort_idle: got active %b sda %b expected 0 1", tx_active, sda_out);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (ack_cnt != a0 || nack_cnt != n0)
      $display("FAIL abort_no_pulse: got %0d/%0d expected 0/0", ack_cnt - a0, nack_cnt - n0);
    else n_pass++;
    push(8'h55);
    start();
    master_byte(1'b0, got, asda);
    n_chk++;
    if (got !== 8'h55) $display("FAIL abort_resend: got %h expected 55", got); else n_pass++;
  endtask

  task automatic test_illegal_edges();
    logic [7:0] got; logic asda;
    push(8'h96);
    start();
    gap();
    scl_rising = 1'b1; scl_falling = 1'b1;
    @(negedge clk);
    scl_rising = 1'b0; scl_falling = 1'b0;
    master_byte(1'b0, got, asda);
    n_chk++;
    if (got !== 8'h96) $display("FAIL illegal_edges: got %h expected 96", got); else n_pass++;
  endtask

  task automatic test_async_reset();
    push(8'h00);
    start();
    n_chk++;
    if (sda_out !== 1'b0) $display("FAIL areset_pre: got %b expected 0", sda_out); else n_pass++;
    #2 n_rst = 1'b0;
    #1;
    n_chk++;
    if ({sda_out, tx_active} !== 2'b10)
      $display("FAIL areset_immediate: got sda %b active %b expected 1 0", sda_out, tx_active);
    else n_pass++;
    @(negedge clk);
    n_rst = 1'b1;
    wr_ptr = rd_ptr;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({sda_out, tx_active} !== 2'b10)
      $display("FAIL areset_idle: got sda %b active %b expected 1 0", sda_out, tx_active);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] data [6]; logic [7:0] got, exp; logic asda;
    for (int it = 0; it < 6; it++) begin
      int unsigned nb = $urandom_range(1, 4);
      int unsigned fill = $urandom_range(0, nb + 1);
      int unsigned p0 = rd_ptr, u0 = und_cnt, a0 = ack_cnt, n0 = nack_cnt;
      int unsigned exp_pops = (fill < nb) ? fill : nb;
      for (int i = 0; i < 6; i++) data[i] = 8'($urandom);
      for (int i = 0; i < int'(fill); i++) push(data[i]);
      start();
      for (int i = 0; i < int'(nb); i++) begin
        master_byte(i < int'(nb) - 1, got, asda);
        exp = (i < int'(fill)) ? data[i] : 8'hFF;
        n_chk++;
        if (got !== exp) $display("FAIL rand_byte[%0d.%0d]: got %h expected %h", it, i, got, exp);
        else n_pass++;
      end
      repeat (2) @(negedge clk);
      n_chk++;
      if (rd_ptr - p0 != exp_pops || und_cnt - u0 != nb - exp_pops ||
          ack_cnt - a0 != nb - 1 || nack_cnt - n0 != 1)
        $display("FAIL rand_counts[%0d]: got pop %0d und %0d ack %0d nack %0d expected %0d %0d %0d 1",
                 it, rd_ptr - p0, und_cnt - u0, ack_cnt - a0, nack_cnt - n0,
                 exp_pops, nb - exp_pops, nb - 1);
      else n_pass++;
      wr_ptr = rd_ptr;
    end
    n_chk++;
    if (bad_pop != 0) $display("FAIL pop_while_empty: got %0d expected 0", bad_pop); else n_pass++;
  endtask

`ifdef TX_BYTE_CNT_EN
  task automatic test_byte_count();
    logic [7:0] got; logic asda;
    for (int i = 0; i < 4; i++) push(8'($urandom));
    start();
    for (int i = 0; i < 4; i++) master_byte(i < 3, got, asda);
    @(negedge clk);
    n_chk++;
    if (tx_byte_count !== 16'd4) $display("FAIL byte_count: got %0d expected 4", tx_byte_count); else n_pass++;
    start();
    n_chk++;
    if (tx_byte_count !== 16'd0) $display("FAIL byte_count_clear: got %0d expected 0", tx_byte_count); else n_pass++;
    master_byte(1'b0, got, asda);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_illegal_edges();
    test_async_reset();
    test_random();
`ifdef TX_BYTE_CNT_EN
    test_byte_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_tx_byte_sender.md
Name: i2c_tx_byte_sender

Overview:
- Downstream consumer of tx_fifo in the I2C Triple-DES slave.
- Pops encrypted bytes from tx_fifo and serialises them MSB-first onto SDA during master-read transfers.
- Samples the master's ACK/NACK and continues or stops accordingly.
- Sits between tx_fifo and the SDA output mux; SCL/SDA arrive as synchronised samples and edge pulses from the existing edge-detect stage.

Parameters:
- DATA_W, 8, byte width; must match tx_fifo data width.
- FILL_BYTE, 8'hFF, byte transmitted when tx_fifo is empty at load time (underrun).

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- start_tx  input  1  1-cycle pulse from the slave controller: a read transfer begins, SCL is low.
- stop_detect  input  1  1-cycle pulse: STOP or repeated START seen on the bus.
- scl_rising  input  1  1-cycle pulse on synchronised SCL rising edge.
- scl_falling  input  1  1-cycle pulse on synchronised SCL falling edge.
- sda_in  input  1  synchronised SDA level.
- fifo_empty  input  1  tx_fifo empty flag.
- read_data  input  DATA_W  tx_fifo head word; valid whenever fifo_empty=0 (first-word fall-through).
- read_enable  output  1  tx_fifo pop strobe.
- sda_out  output  1  SDA drive value: 0 pulls low, 1 releases.
- tx_active  output  1  high in any state other than IDLE.
- ack_pulse  output  1  1-cycle pulse: master ACKed a byte.
- nack_pulse  output  1  1-cycle pulse: master NACKed a byte.
- underrun  output  1  1-cycle pulse: FILL_BYTE was loaded because the FIFO was empty.

Behaviour:
- Reset (async, n_rst=0): state=IDLE, shift_reg=FILL_BYTE, bit_cnt=0, sda_out=1, read_enable=0, tx_active=0, all pulses 0. Reset mid-byte releases SDA immediately.
- States: IDLE, SHIFT, ACK_WAIT, ACK_HOLD.
- Load operation, used on entry to SHIFT:
  - fifo_empty=0: shift_reg<=read_data; read_enable=1 combinationally in that same cycle only.
  - fifo_empty=1: shift_reg<=FILL_BYTE; underrun pulses; read_enable stays 0.
  - In both cases bit_cnt<=0 and sda_out<=MSB of the loaded byte at the next edge.
- IDLE: sda_out=1. start_tx -> load -> SHIFT. All other inputs ignored.
- SHIFT:
  - On scl_falling with bit_cnt<7: shift left by one, sda_out<=next bit, bit_cnt++.
  - On scl_falling with bit_cnt==7: sda_out<=1 (release for ACK), go to ACK_WAIT.
  - scl_rising is ignored; the master samples the bit.
- ACK_WAIT: on scl_rising, sample sda_in.
  - sda_in=0: ack_pulse, go to ACK_HOLD.
  - sda_in=1: nack_pulse, go to IDLE.
- ACK_HOLD: on scl_falling -> load next byte -> SHIFT. The master's ACK cycle ends before slave data is driven.
- read_enable never pulses more than once per byte; never pulses while fifo_empty=1.
- stop_detect takes priority over every other input in every state:
  - Next state IDLE, sda_out=1.
  - No pop and no ack/nack pulse in that cycle.
- If scl_rising and scl_falling are asserted together (illegal), both are ignored.
- Latency: start_tx at edge N -> sda_out=MSB valid after edge N+1.
- bit_cnt is 3 bits and never exceeds 7.

Optional Feature:
- Macro: TX_BYTE_CNT_EN.
- Defined: adds output tx_byte_count [15:0], reset 0.
  - Cleared to 0 on start_tx in IDLE.
  - Incremented on every ack_pulse or nack_pulse (byte completed).
  - Saturates at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package i2c_pkg holds:
  - State enum type tx_state_t (IDLE, SHIFT, ACK_WAIT, ACK_HOLD).
  - Constants I2C_BYTE_W=8 and I2C_FILL_BYTE=8'hFF, used as parameter defaults.
- One natural sub-module, tx_shift_reg:
  - DATA_W-bit parallel-load / shift-left register.
  - Inputs load, shift, load_data; output msb.
- The FSM, bit counter and pulse generation stay in the top module.

Test Plan:
- Basic send: preload FIFO with 8'hA5, pulse start_tx, apply 8 SCL periods.
  - read_enable pulses once.
  - sda_out sequence at each scl_rising = 1,0,1,0,0,1,0,1.
  - sda_out=1 during the ACK clock.
  - sda_in=1 at the ACK rising edge -> nack_pulse, state IDLE.
- Back-to-back: FIFO holds 8'h3C, 8'hC3; master ACKs the first byte, NACKs the second.
  - Bytes appear in order; exactly two read_enable pulses.
  - One ack_pulse, then one nack_pulse.
  - fifo_empty=1 at the end.
- Underrun: FIFO holds 8'h81 only; master ACKs.
  - Second byte is 8'hFF; underrun pulses once; no read_enable while empty.
- Abort: stop_detect asserted after 3 bits of 8'h0F.
  - State IDLE, sda_out=1 next cycle.
  - No ack/nack pulse; a following start_tx with FIFO holding 8'h55 sends 8'h55 cleanly.
- Async reset: drive n_rst=0 mid-SHIFT with sda_out=0.
  - sda_out=1 and tx_active=0 without waiting for clk.
  - After release, the FSM is in IDLE.
- TX_BYTE_CNT_EN build: 3 ACKed bytes followed by a NACK -> tx_byte_count=4; the next start_tx clears it to 0.
